// File: rtl/mpc_sequencer_pkg.sv
// Shared types for the ALU instruction sequencer: op encodings, FSM states and the ALU function.
package mpc_sequencer_pkg;

  typedef enum logic [1:0] {
    OpDec = 2'b00,
    OpSub = 2'b01,
    OpInc = 2'b10,
    OpAdd = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    StIdle,
    StRd,
    StEx,
    StWb
  } state_e;

  // 9-bit result {carry/borrow, sum}; operands zero-extended, subtraction wraps modulo 512.
  function automatic logic [8:0] alu_calc(input op_e op, input logic [7:0] a,
                                          input logic [7:0] b);
    logic [8:0] r;
    r = 9'h000;
    unique case (op)
      OpAdd:   r = {1'b0, a} + {1'b0, b};
      OpInc:   r = {1'b0, a} + 9'd1;
      OpSub:   r = {1'b0, a} - {1'b0, b};
      OpDec:   r = {1'b0, a} - 9'd1;
      default: r = 9'h000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mpc_sequencer_ifq.sv
// Instruction queue: DEPTH-entry synchronous FIFO, read data taken straight from registered storage.
module mpc_sequencer_ifq #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign full    = (count_q == (AW + 1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop) rptr_q <= rptr_q + 1'b1;
      if (do_push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (do_pop && !do_push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/mpc_sequencer.sv
// Instruction sequencer: queues register-based ALU ops, runs them one at a time, writes back on
// result handshake. Owns the register file and carry flag.
module mpc_sequencer
  import mpc_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned NREG  = 4,
  localparam int unsigned RW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    in_op,
  input  logic [RW-1:0] in_rd,
  input  logic [RW-1:0] in_ra,
  input  logic [RW-1:0] in_rb,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [8:0]    res_data,
  output logic          flag_c,
  input  logic          hw_en,
  input  logic [RW-1:0] hw_addr,
  input  logic [7:0]    hw_data,
  output logic          busy
);

  localparam int unsigned IW = 2 + 3 * RW;

  state_e        state_q, state_d;
  logic [IW-1:0] ir_q, q_rdata;
  logic          q_full, q_empty, q_pop, wb_fire;
  logic [7:0]    a_q, b_q;
  logic [8:0]    res_data_q;
  logic          res_valid_q, flag_c_q;
  logic [7:0]    regs_q [NREG];

  op_e           ir_op;
  logic [RW-1:0] ir_rd, ir_ra, ir_rb;

  // Instruction word layout {op, rd, ra, rb}.
  assign ir_op = op_e'(ir_q[IW-1 -: 2]);
  assign ir_rd = ir_q[3*RW-1 -: RW];
  assign ir_ra = ir_q[2*RW-1 -: RW];
  assign ir_rb = ir_q[RW-1:0];

  mpc_sequencer_ifq #(
    .DEPTH (DEPTH),
    .W     (IW)
  ) u_ifq (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid && in_ready),
    .pop   (q_pop),
    .wdata ({in_op, in_rd, in_ra, in_rb}),
    .rdata (q_rdata),
    .full  (q_full),
    .empty (q_empty)
  );

  always_comb begin
    state_d = state_q;
    q_pop   = 1'b0;
    wb_fire = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!q_empty) begin
          q_pop   = 1'b1;
          state_d = StRd;
        end
      end
      StRd: state_d = StEx;
      StEx: state_d = StWb;
      StWb: begin
        if (res_valid_q && res_ready) begin
          wb_fire = 1'b1;
          if (!q_empty) begin
            q_pop   = 1'b1;
            state_d = StRd;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      ir_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      flag_c_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (q_pop) ir_q <= q_rdata;
      if (state_q == StRd) begin
        a_q <= regs_q[ir_ra];
        b_q <= regs_q[ir_rb];
      end
      if (state_q == StEx) begin
        res_data_q  <= alu_calc(ir_op, a_q, b_q);
        res_valid_q <= 1'b1;
      end
      if (wb_fire) begin
        res_valid_q <= 1'b0;
        flag_c_q    <= res_data_q[8];
      end
    end
  end

  // Writeback is assigned last so it overrides a colliding host write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      if (hw_en) regs_q[hw_addr] <= hw_data;
      if (wb_fire) regs_q[ir_rd] <= res_data_q[7:0];
    end
  end

  assign in_ready  = !q_full;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign flag_c    = flag_c_q;
  assign busy      = (state_q != StIdle) || !q_empty;

endmodule

// File: tb/tb_mpc_sequencer.sv
// Directed bench for mpc_sequencer: hand-computed results, latency, backpressure, reset, collisions.
module tb_mpc_sequencer;

  localparam int unsigned RW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [1:0]    in_op;
  logic [RW-1:0] in_rd, in_ra, in_rb;
  logic          res_valid, res_ready;
  logic [8:0]    res_data;
  logic          flag_c;
  logic          hw_en;
  logic [RW-1:0] hw_addr;
  logic [7:0]    hw_data;
  logic          busy;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] ADD = 2'b11, INC = 2'b10, SUB = 2'b01, DEC = 2'b00;

  always #5 clk = ~clk;

  mpc_sequencer #(
    .DEPTH (4),
    .NREG  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_rd     (in_rd),
    .in_ra     (in_ra),
    .in_rb     (in_rb),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .flag_c    (flag_c),
    .hw_en     (hw_en),
    .hw_addr   (hw_addr),
    .hw_data   (hw_data),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // All tasks start and end just after a negedge.
  task automatic hw_wr(input logic [RW-1:0] a, input logic [7:0] d);
    hw_en   = 1'b1;
    hw_addr = a;
    hw_data = d;
    @(negedge clk);
    hw_en = 1'b0;
  endtask

  task automatic push(input string tag, input logic [1:0] op, input logic [RW-1:0] rd,
                      input logic [RW-1:0] ra, input logic [RW-1:0] rb);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_op    = op;
    in_rd    = rd;
    in_ra    = ra;
    in_rb    = rb;
    for (int i = 0; i < 50; i++) begin
      if (in_ready) begin
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!ok) check({tag, "_push_timeout"}, 16'd0, 16'd1);
  endtask

  task automatic get_res(input string tag, input logic [8:0] exp);
    bit ok = 1'b0;
    res_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (res_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) check(tag, 16'(res_data), 16'(exp));
    else check({tag, "_timeout"}, 16'd0, 16'd1);
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  int first_idx, last_idx, nres;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_rd = '0; in_ra = '0; in_rb = '0;
    res_ready = 1'b0; hw_en = 1'b0; hw_addr = '0; hw_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_res_valid", 16'(res_valid), 16'd0);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_in_ready", 16'(in_ready), 16'd1);
    check("rst_flag_c", 16'(flag_c), 16'd0);
    check("rst_res_data", 16'(res_data), 16'd0);
    push("rd01", ADD, 2'd3, 2'd0, 2'd1);
    get_res("rst_r0_plus_r1", 9'h000);
    push("rd2", INC, 2'd3, 2'd2, 2'd0);
    get_res("rst_r2_inc", 9'h001);

    // SUB with borrow and exact latency
    hw_wr(2'd0, 8'h03);
    hw_wr(2'd1, 8'h05);
    push("sub", SUB, 2'd2, 2'd0, 2'd1);
    check("lat_t0", 16'(res_valid), 16'd0);
    @(negedge clk);
    check("lat_t1", 16'(res_valid), 16'd0);
    @(negedge clk);
    check("lat_t2", 16'(res_valid), 16'd0);
    check("lat_busy", 16'(busy), 16'd1);
    @(negedge clk);
    check("lat_t3", 16'(res_valid), 16'd1);
    check("sub_data", 16'(res_data), 16'h1FE);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("sub_flag_c", 16'(flag_c), 16'd1);
    check("sub_valid_drop", 16'(res_valid), 16'd0);
    push("rdr2", INC, 2'd3, 2'd2, 2'd0);
    get_res("sub_r2_is_fe", 9'h0FF);
    check("inc_flag_c", 16'(flag_c), 16'd0);

    // Carry cases
    hw_wr(2'd0, 8'hFF);
    hw_wr(2'd1, 8'h01);
    push("add", ADD, 2'd2, 2'd0, 2'd1);
    get_res("add_ff_01", 9'h100);
    check("add_flag_c", 16'(flag_c), 16'd1);
    push("rdr2b", INC, 2'd3, 2'd2, 2'd0);
    get_res("add_r2_is_00", 9'h001);
    push("inc", INC, 2'd3, 2'd0, 2'd0);
    get_res("inc_ff", 9'h100);
    push("dec", DEC, 2'd2, 2'd2, 2'd0);
    get_res("dec_00", 9'h1FF);
    check("dec_flag_c", 16'(flag_c), 16'd1);
    push("rdr2c", INC, 2'd3, 2'd2, 2'd0);
    get_res("dec_r2_is_ff", 9'h100);

    // Queue full under backpressure, ordering preserved
    hw_wr(2'd0, 8'h10);
    hw_wr(2'd1, 8'h01);
    hw_wr(2'd2, 8'h20);
    push("q1", ADD, 2'd3, 2'd0, 2'd1);
    push("q2", SUB, 2'd3, 2'd0, 2'd1);
    push("q3", INC, 2'd3, 2'd2, 2'd0);
    push("q4", DEC, 2'd3, 2'd2, 2'd0);
    push("q5", ADD, 2'd3, 2'd2, 2'd0);
    check("full_in_ready", 16'(in_ready), 16'd0);
    in_valid = 1'b1; in_op = SUB; in_rd = 2'd3; in_ra = 2'd1; in_rb = 2'd0;
    repeat (3) @(negedge clk);
    check("stall_in_ready", 16'(in_ready), 16'd0);
    check("stall_res_valid", 16'(res_valid), 16'd1);
    check("q1_data", 16'(res_data), 16'h011);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("after_hs_in_ready", 16'(in_ready), 16'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("q6_refill_full", 16'(in_ready), 16'd0);
    get_res("q2_data", 9'h00F);
    get_res("q3_data", 9'h021);
    get_res("q4_data", 9'h01F);
    get_res("q5_data", 9'h030);
    get_res("q6_data", 9'h1F1);

    // Back-to-back dependent INCs
    hw_wr(2'd0, 8'h00);
    res_ready = 1'b1;
    first_idx = -1; last_idx = -1; nres = 0;
    for (int i = 0; i < 30; i++) begin
      if (res_valid) begin
        check($sformatf("b2b_data%0d", nres), 16'(res_data), 16'(nres + 1));
        if (first_idx < 0) first_idx = i;
        else check($sformatf("b2b_gap%0d", nres), 16'(i - last_idx), 16'd3);
        last_idx = i;
        nres++;
      end
      in_valid = (i < 4);
      in_op = INC; in_rd = 2'd0; in_ra = 2'd0; in_rb = 2'd0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    res_ready = 1'b0;
    check("b2b_first_idx", 16'(first_idx), 16'd4);
    check("b2b_count", 16'(nres), 16'd4);

    // Reset while in EX with two queued
    hw_wr(2'd0, 8'h05);
    push("r1", INC, 2'd1, 2'd0, 2'd0);
    push("r2", INC, 2'd1, 2'd0, 2'd0);
    push("r3", INC, 2'd1, 2'd0, 2'd0);
    check("pre_rst_busy", 16'(busy), 16'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_res_valid", 16'(res_valid), 16'd0);
    check("mid_rst_busy", 16'(busy), 16'd0);
    check("mid_rst_in_ready", 16'(in_ready), 16'd1);
    repeat (5) @(negedge clk);
    check("mid_rst_quiet", 16'(res_valid | busy), 16'd0);
    push("rdr1", INC, 2'd3, 2'd1, 2'd0);
    get_res("mid_rst_r1_is_00", 9'h001);

    // Host write collides with writeback to the same register
    hw_wr(2'd0, 8'h07);
    push("c1", INC, 2'd2, 2'd0, 2'd0);
    repeat (3) @(negedge clk);
    check("coll_valid", 16'(res_valid), 16'd1);
    res_ready = 1'b1;
    hw_en = 1'b1; hw_addr = 2'd2; hw_data = 8'hAA;
    @(negedge clk);
    res_ready = 1'b0;
    hw_en = 1'b0;
    push("rdc", INC, 2'd3, 2'd2, 2'd0);
    get_res("coll_wb_wins", 9'h009);

    // Host write to a different register in the writeback cycle
    push("c2", DEC, 2'd2, 2'd0, 2'd0);
    repeat (3) @(negedge clk);
    res_ready = 1'b1;
    hw_en = 1'b1; hw_addr = 2'd1; hw_data = 8'h55;
    @(negedge clk);
    res_ready = 1'b0;
    hw_en = 1'b0;
    push("rdc2", INC, 2'd3, 2'd2, 2'd0);
    get_res("nocoll_r2", 9'h007);
    push("rdc1", INC, 2'd3, 2'd1, 2'd0);
    get_res("nocoll_r1", 9'h056);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
